// File: rtl/simd_top.sv
// Four-lane 32-bit SIMD execution unit.
// An instruction (opcode + burst length) is latched in IDLE, then a burst of
// 128-bit operand pairs is processed lane-wise through a two-stage pipeline:
// stage 1 captures the accepted beat, stage 2 computes and registers the result.
module simd_top (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_instruction,
  input  logic [2:0]   instruction,
  input  logic [5:0]   data_size,
  input  logic         valid_data,
  input  logic [127:0] mc_data_in_opa,
  input  logic [127:0] mc_data_in_opb,
  output logic [31:0]  out_procc0,
  output logic [31:0]  out_procc1,
  output logic [31:0]  out_procc2,
  output logic [31:0]  out_procc3,
  output logic [31:0]  out_extra_procc0,
  output logic [31:0]  out_extra_procc1,
  output logic [31:0]  out_extra_procc2,
  output logic [31:0]  out_extra_procc3
);

  localparam int LANES = 4;
  localparam int LW    = 32;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [2:0] OP_NOP    = 3'b000;
  localparam logic [2:0] OP_ADD    = 3'b001;
  localparam logic [2:0] OP_SUB    = 3'b010;
  localparam logic [2:0] OP_LOGIC  = 3'b011;
  localparam logic [2:0] OP_MINMAX = 3'b100;
  localparam logic [2:0] OP_MUL    = 3'b101;
  localparam logic [2:0] OP_MAC    = 3'b110;

  logic [0:0] state_reg;
  logic [2:0] op_reg;
  logic [5:0] size_reg;
  logic [5:0] beat_cnt_reg;

  logic                  s1_valid_reg;
  logic [2:0]            s1_op_reg;
  logic [LANES*LW-1:0]   s1_a_reg;
  logic [LANES*LW-1:0]   s1_b_reg;

  logic [LANES*LW-1:0]   out_bus;
  logic [LANES*LW-1:0]   extra_bus;

  logic start;
  logic accept;

  // A new instruction is only taken in IDLE; beats are only taken in RUN.
  assign start  = (state_reg == ST_IDLE) && valid_instruction;
  assign accept = (state_reg == ST_RUN) && valid_data;

  // Control FSM: latch the instruction, count accepted beats, end the burst
  // after the last beat or on the first gap in valid_data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      op_reg       <= OP_NOP;
      size_reg     <= '0;
      beat_cnt_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (valid_instruction) begin
            op_reg       <= instruction;
            size_reg     <= data_size;
            beat_cnt_reg <= '0;
            state_reg    <= ST_RUN;
          end
        end
        default: begin
          if (valid_data) begin
            beat_cnt_reg <= beat_cnt_reg + 6'd1;
            if (beat_cnt_reg == size_reg) begin
              state_reg <= ST_IDLE;
            end
          end else begin
            state_reg <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // Stage 1: capture the accepted beat together with its opcode, so a beat
  // still in flight finishes with the operation it was issued under.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
      s1_op_reg    <= OP_NOP;
      s1_a_reg     <= '0;
      s1_b_reg     <= '0;
    end else begin
      s1_valid_reg <= accept;
      s1_op_reg    <= op_reg;
      if (accept) begin
        s1_a_reg <= mc_data_in_opa;
        s1_b_reg <= mc_data_in_opb;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi = gi + 1) begin : g_lane
      logic [LW-1:0]   lane_a;
      logic [LW-1:0]   lane_b;
      logic [LW:0]     sum_ext;
      logic [2*LW-1:0] prod;
      logic [2*LW-1:0] mac_sum;
      logic [2*LW-1:0] acc_reg;
      logic [LW-1:0]   out_reg;
      logic [LW-1:0]   extra_reg;
      logic [LW-1:0]   res_out;
      logic [LW-1:0]   res_extra;
      logic            res_wr;

      assign lane_a  = s1_a_reg[gi*LW +: LW];
      assign lane_b  = s1_b_reg[gi*LW +: LW];
      assign sum_ext = {1'b0, lane_a} + {1'b0, lane_b};
      assign prod    = {{LW{1'b0}}, lane_a} * {{LW{1'b0}}, lane_b};
      assign mac_sum = acc_reg + prod;

      // Stage 2 datapath: select this lane's result; NOP/reserved write nothing.
      always_comb begin
        res_out   = '0;
        res_extra = '0;
        res_wr    = 1'b1;
        case (s1_op_reg)
          OP_ADD: begin
            res_out   = sum_ext[LW-1:0];
            res_extra = {{(LW-1){1'b0}}, sum_ext[LW]};
          end
          OP_SUB: begin
            res_out   = lane_a - lane_b;
            res_extra = {{(LW-1){1'b0}}, (lane_a < lane_b)};
          end
          OP_LOGIC: begin
            res_out   = lane_a & lane_b;
            res_extra = lane_a | lane_b;
          end
          OP_MINMAX: begin
            res_out   = (lane_a > lane_b) ? lane_a : lane_b;
            res_extra = (lane_a > lane_b) ? lane_b : lane_a;
          end
          OP_MUL: begin
            res_out   = prod[LW-1:0];
            res_extra = prod[2*LW-1:LW];
          end
          OP_MAC: begin
            res_out   = mac_sum[LW-1:0];
            res_extra = mac_sum[2*LW-1:LW];
          end
          default: begin
            res_wr = 1'b0;
          end
        endcase
      end

      // Stage 2 registers: outputs change only when a result retires; the
      // accumulator clears on a new instruction, which wins over a trailing
      // MAC beat from the previous burst (that beat still drives the outputs).
      always_ff @(posedge clk) begin
        if (reset) begin
          out_reg   <= '0;
          extra_reg <= '0;
          acc_reg   <= '0;
        end else begin
          if (s1_valid_reg && res_wr) begin
            out_reg   <= res_out;
            extra_reg <= res_extra;
          end
          if (start) begin
            acc_reg <= '0;
          end else if (s1_valid_reg && (s1_op_reg == OP_MAC)) begin
            acc_reg <= mac_sum;
          end
        end
      end

      assign out_bus[gi*LW +: LW]   = out_reg;
      assign extra_bus[gi*LW +: LW] = extra_reg;
    end
  endgenerate

  assign out_procc0       = out_bus[0*LW +: LW];
  assign out_procc1       = out_bus[1*LW +: LW];
  assign out_procc2       = out_bus[2*LW +: LW];
  assign out_procc3       = out_bus[3*LW +: LW];
  assign out_extra_procc0 = extra_bus[0*LW +: LW];
  assign out_extra_procc1 = extra_bus[1*LW +: LW];
  assign out_extra_procc2 = extra_bus[2*LW +: LW];
  assign out_extra_procc3 = extra_bus[3*LW +: LW];

endmodule

// File: tb/tb_simd_top.sv
// Bench for simd_top: directed bursts, a per-beat arithmetic model feeding a
// time-stamped result queue, and a negedge compare of all eight outputs.
module tb_simd_top;

  logic         clk = 1'b0;
  logic         reset;
  logic         valid_instruction;
  logic [2:0]   instruction;
  logic [5:0]   data_size;
  logic         valid_data;
  logic [127:0] mc_data_in_opa;
  logic [127:0] mc_data_in_opb;
  logic [31:0]  out_procc0, out_procc1, out_procc2, out_procc3;
  logic [31:0]  out_extra_procc0, out_extra_procc1, out_extra_procc2, out_extra_procc3;

  simd_top dut (
    .clk               (clk),
    .reset             (reset),
    .valid_instruction (valid_instruction),
    .instruction       (instruction),
    .data_size         (data_size),
    .valid_data        (valid_data),
    .mc_data_in_opa    (mc_data_in_opa),
    .mc_data_in_opb    (mc_data_in_opb),
    .out_procc0        (out_procc0),
    .out_procc1        (out_procc1),
    .out_procc2        (out_procc2),
    .out_procc3        (out_procc3),
    .out_extra_procc0  (out_extra_procc0),
    .out_extra_procc1  (out_extra_procc1),
    .out_extra_procc2  (out_extra_procc2),
    .out_extra_procc3  (out_extra_procc3)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]  due;
    logic [127:0] o;
    logic [127:0] e;
  } ent_t;

  ent_t         pend_q[$];
  logic [31:0]  cyc = 32'd0;
  logic [31:0]  exp_o[4];
  logic [31:0]  exp_e[4];
  logic [63:0]  macc[4];
  logic [127:0] va[64];
  logic [127:0] vb[64];
  logic [31:0]  dut_o[4];
  logic [31:0]  dut_e[4];
  bit           check_en = 1'b0;
  int           n_cmp = 0;
  int           n_bad = 0;

  assign dut_o[0] = out_procc0;
  assign dut_o[1] = out_procc1;
  assign dut_o[2] = out_procc2;
  assign dut_o[3] = out_procc3;
  assign dut_e[0] = out_extra_procc0;
  assign dut_e[1] = out_extra_procc1;
  assign dut_e[2] = out_extra_procc2;
  assign dut_e[3] = out_extra_procc3;

  always @(posedge clk) cyc <= cyc + 32'd1;

  // Result of one accepted beat, worked out from the opcode table.
  function automatic void model_beat(input logic [2:0] op, input logic [127:0] a,
                                     input logic [127:0] b, input logic [31:0] due);
    ent_t        ent;
    logic [31:0] x, y, ro, re;
    logic [63:0] p, s;
    if (op == 3'd0 || op == 3'd7) return;
    ent.due = due;
    ent.o   = '0;
    ent.e   = '0;
    for (int l = 0; l < 4; l++) begin
      x  = a[l*32 +: 32];
      y  = b[l*32 +: 32];
      p  = 64'(x) * 64'(y);
      s  = 64'(x) + 64'(y);
      ro = 32'd0;
      re = 32'd0;
      case (op)
        3'd1: begin ro = x + y; re = (s > 64'h0000_0000_FFFF_FFFF) ? 32'd1 : 32'd0; end
        3'd2: begin ro = x - y; re = (x < y) ? 32'd1 : 32'd0; end
        3'd3: begin ro = x & y; re = x | y; end
        3'd4: begin ro = (x >= y) ? x : y; re = (x >= y) ? y : x; end
        3'd5: begin ro = p[31:0]; re = p[63:32]; end
        default: begin macc[l] = macc[l] + p; ro = macc[l][31:0]; re = macc[l][63:32]; end
      endcase
      ent.o[l*32 +: 32] = ro;
      ent.e[l*32 +: 32] = re;
    end
    pend_q.push_back(ent);
  endfunction

  // Compare process: retire due model results, then check all eight outputs.
  always @(negedge clk) begin
    if (check_en) begin
      while (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        for (int l = 0; l < 4; l++) begin
          exp_o[l] = pend_q[0].o[l*32 +: 32];
          exp_e[l] = pend_q[0].e[l*32 +: 32];
        end
        void'(pend_q.pop_front());
      end
      for (int l = 0; l < 4; l++) begin
        n_cmp++;
        if (dut_o[l] !== exp_o[l]) begin
          n_bad++;
          $display("FAIL out_procc%0d cyc=%0d actual=%h required=%h", l, cyc, dut_o[l], exp_o[l]);
        end
        n_cmp++;
        if (dut_e[l] !== exp_e[l]) begin
          n_bad++;
          $display("FAIL out_extra_procc%0d cyc=%0d actual=%h required=%h", l, cyc, dut_e[l], exp_e[l]);
        end
      end
    end
  end

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end else begin
      $display("check %s = %h ok", name, act);
    end
  endtask

  task automatic idle(input int n);
    valid_data        = 1'b0;
    valid_instruction = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    pend_q.delete();
    for (int l = 0; l < 4; l++) begin
      exp_o[l] = 32'd0;
      exp_e[l] = 32'd0;
      macc[l]  = 64'd0;
    end
    reset = 1'b0;
    $display("reset applied at cyc=%0d", cyc);
  endtask

  task automatic issue(input logic [2:0] op, input logic [5:0] size);
    valid_instruction = 1'b1;
    instruction       = op;
    data_size         = size;
    valid_data        = 1'b0;
    @(posedge clk);
    #1;
    valid_instruction = 1'b0;
    for (int l = 0; l < 4; l++) macc[l] = 64'd0;
    $display("instr op=%0d size=%0d cyc=%0d", op, size, cyc);
  endtask

  // Instruction plus nbeats consecutive beats from va/vb. Beats past the
  // burst length land in IDLE and are ignored; a short burst ends with a gap.
  task automatic burst(input logic [2:0] op, input int size, input int nbeats);
    issue(op, 6'(size));
    for (int k = 0; k < nbeats; k++) begin
      valid_data     = 1'b1;
      mc_data_in_opa = va[k];
      mc_data_in_opb = vb[k];
      @(posedge clk);
      #1;
      if (k <= size) model_beat(op, va[k], vb[k], cyc + 32'd1);
      $display("beat %0d op=%0d a=%h b=%h accepted=%0d", k, op, va[k], vb[k], (k <= size));
    end
    valid_data = 1'b0;
    if (nbeats < size + 1) idle(1);
  endtask

  task automatic fill_all(input int k, input logic [31:0] a, input logic [31:0] b);
    va[k] = {a, a, a, a};
    vb[k] = {b, b, b, b};
  endtask

  initial begin
    reset = 1'b1;
    valid_instruction = 1'b0;
    instruction = 3'd0;
    data_size = 6'd0;
    valid_data = 1'b0;
    mc_data_in_opa = '0;
    mc_data_in_opb = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    check_en = 1'b1;
    idle(1);
    lit("reset_out0", out_procc0, 32'h0);
    lit("reset_extra3", out_extra_procc3, 32'h0);

    // ADD with lane0 carry-out, other lanes varied
    va[0] = {32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0005, 32'hFFFF_FFFF};
    vb[0] = {32'h0000_0001, 32'h8000_0000, 32'h0000_0003, 32'h0000_0001};
    burst(3'd1, 0, 1);
    idle(2);
    lit("add_out0", out_procc0, 32'h0000_0000);
    lit("add_extra0", out_extra_procc0, 32'h0000_0001);
    lit("add_out2", out_procc2, 32'h0000_0000);
    lit("add_extra2", out_extra_procc2, 32'h0000_0001);

    // SUB with borrow in all lanes
    fill_all(0, 32'h1111_1111, 32'h2222_2222);
    burst(3'd2, 0, 1);
    idle(2);
    lit("sub_out1", out_procc1, 32'hEEEE_EEEF);
    lit("sub_extra1", out_extra_procc1, 32'h0000_0001);

    // LOGIC then MINMAX, two beats each, mixed orderings per lane
    va[0] = {32'hF0F0_F0F0, 32'h0000_0001, 32'h1234_5678, 32'hFFFF_0000};
    vb[0] = {32'h0FF0_0FF0, 32'h0000_0002, 32'h1234_5678, 32'h00FF_FF00};
    va[1] = {32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0000, 32'hDEAD_BEEF};
    vb[1] = {32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hCAFE_F00D};
    burst(3'd3, 1, 2);
    idle(2);
    lit("logic_out0", out_procc0, 32'hCAAC_B00D);
    burst(3'd4, 1, 2);
    idle(2);
    lit("minmax_out3", out_procc3, 32'h8000_0000);
    lit("minmax_extra3", out_extra_procc3, 32'h7FFF_FFFF);

    // NOP burst: outputs must hold
    burst(3'd0, 1, 2);
    idle(2);
    lit("nop_hold_out3", out_procc3, 32'h8000_0000);

    // MUL, 16 beats
    for (int k = 0; k < 15; k++) fill_all(k, 32'h1111_1111, 32'h1111_1111);
    fill_all(7, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    fill_all(15, 32'hFFFF_FFFF, 32'h0000_0001);
    burst(3'd5, 15, 16);
    idle(2);
    lit("mul_out0", out_procc0, 32'hFFFF_FFFF);
    lit("mul_extra0", out_extra_procc0, 32'h0000_0000);
    fill_all(0, 32'h1111_1111, 32'h1111_1111);
    burst(3'd5, 0, 1);
    idle(2);
    lit("mul_sq_out2", out_procc2, 32'h8765_4321);
    lit("mul_sq_extra2", out_extra_procc2, 32'h0123_4567);

    // MAC, two beats plus a third that must be ignored
    fill_all(0, 32'd2, 32'd3);
    fill_all(1, 32'd4, 32'd5);
    fill_all(2, 32'd100, 32'd100);
    burst(3'd6, 1, 3);
    idle(3);
    lit("mac_out0", out_procc0, 32'h0000_001A);
    lit("mac_extra0", out_extra_procc0, 32'h0000_0000);

    // MAC wrap, then a back-to-back MAC that must start from zero
    fill_all(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    fill_all(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    fill_all(2, 32'hFFFF_FFFF, 32'h0000_0002);
    burst(3'd6, 2, 3);
    fill_all(0, 32'd7, 32'd6);
    burst(3'd6, 0, 1);
    idle(2);
    lit("mac_b2b_out1", out_procc1, 32'h0000_002A);

    // Early end: 3 of 16 beats, then a clean restart
    fill_all(0, 32'd1, 32'd1);
    fill_all(1, 32'd2, 32'd2);
    fill_all(2, 32'h1000_0000, 32'h0000_0010);
    burst(3'd5, 15, 3);
    idle(2);
    lit("early_extra0", out_extra_procc0, 32'h0000_0001);
    fill_all(0, 32'd40, 32'd2);
    burst(3'd1, 0, 1);
    idle(2);
    lit("restart_out3", out_procc3, 32'd42);

    // Reset mid-burst, then beats without an instruction are ignored
    fill_all(0, 32'd9, 32'd1);
    fill_all(1, 32'd8, 32'd1);
    issue(3'd1, 6'd15);
    valid_data = 1'b1;
    mc_data_in_opa = va[0];
    mc_data_in_opb = vb[0];
    @(posedge clk);
    #1;
    model_beat(3'd1, va[0], vb[0], cyc + 32'd1);
    mc_data_in_opa = va[1];
    mc_data_in_opb = vb[1];
    do_reset();
    valid_data = 1'b1;
    for (int k = 0; k < 3; k++) begin
      mc_data_in_opa = {4{32'h5555_5555}};
      mc_data_in_opb = {4{32'h1111_1111}};
      @(posedge clk);
      #1;
      $display("ignored beat %0d cyc=%0d", k, cyc);
    end
    idle(3);
    lit("rst_mid_out0", out_procc0, 32'h0);
    lit("rst_mid_extra0", out_extra_procc0, 32'h0);

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
